// File: rtl/fifo_mem_param_if.sv
// Producer/consumer bundle for fifo_mem_param: requests in, status and read word out.
interface fifo_mem_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              flush;
  logic              err_clr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              wr_err;
  logic              rd_err;

  modport master (
    output wr_en, wr_data, rd_en, flush, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, wr_err, rd_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, wr_err, rd_err
  );
endinterface

// File: rtl/fifo_mem_param.sv
// Single-clock parametrised FIFO with occupancy, threshold flags, sticky errors,
// synchronous flush and optional show-ahead read port.
module fifo_mem_param #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned AF_THRESH  = DEPTH - 4,
  parameter int unsigned AE_THRESH  = 4,
  parameter bit          SHOW_AHEAD = 1'b0
) (
  input  logic             CLK,
  input  logic             nRST,
  fifo_mem_param_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              af_q;
  logic              ae_q;
  logic              wr_err_q;
  logic              rd_err_q;
  logic              rd_acc;
  logic              wr_acc;

  // Accept decisions use pre-edge flags; a read frees a slot for a same-cycle write at full.
  always_comb begin
    rd_acc    = bus.rd_en & ~empty_q;
    wr_acc    = bus.wr_en & (~full_q | rd_acc);
    count_nxt = count_q;
    if (bus.flush) begin
      count_nxt = '0;
    end else if (wr_acc & ~rd_acc) begin
      count_nxt = count_q + CNT_W'(1);
    end else if (rd_acc & ~wr_acc) begin
      count_nxt = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= CNT_W'(AF_THRESH));
      ae_q    <= (count_nxt <= CNT_W'(AE_THRESH));
      // A new error outranks err_clr; flush suppresses error detection.
      if (!bus.flush && bus.wr_en && !wr_acc) wr_err_q <= 1'b1;
      else if (bus.err_clr)                   wr_err_q <= 1'b0;
      if (!bus.flush && bus.rd_en && empty_q) rd_err_q <= 1'b1;
      else if (bus.err_clr)                   rd_err_q <= 1'b0;
    end
  end

  // Storage is not reset; only accepted, non-flushed writes touch it.
  always_ff @(posedge CLK) begin
    if (wr_acc && !bus.flush) mem[wr_ptr] <= bus.wr_data;
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      assign bus.rd_data  = mem[rd_ptr];
      assign bus.rd_valid = ~empty_q;
    end else begin : g_reg_read
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc & ~bus.flush;
          if (rd_acc && !bus.flush) rd_data_q <= mem[rd_ptr];
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.wr_err       = wr_err_q;
  assign bus.rd_err       = rd_err_q;
endmodule

// File: tb/tb_fifo_mem_param.sv
// Bench for fifo_mem_param: registered-read and show-ahead instances driven in lockstep
// and compared every cycle against a queue model, plus directed literal checks.
module tb_fifo_mem_param;
  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 32;
  localparam int unsigned CW  = 6;
  localparam int unsigned AF  = 28;
  localparam int unsigned AE  = 4;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  fifo_mem_param_if #(.DATA_W(DW), .DEPTH(DEP)) b0 ();
  fifo_mem_param_if #(.DATA_W(DW), .DEPTH(DEP)) b1 ();

  fifo_mem_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE), .SHOW_AHEAD(1'b0))
    u_reg (.CLK(CLK), .nRST(nRST), .bus(b0.slave));
  fifo_mem_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF), .AE_THRESH(AE), .SHOW_AHEAD(1'b1))
    u_sa (.CLK(CLK), .nRST(nRST), .bus(b1.slave));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_rd_data;
  bit            m_rd_valid;
  bit            m_wr_err;
  bit            m_rd_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit we, input logic [DW-1:0] wd, input bit re, input bit fl, input bit ec);
    b0.wr_en = we; b0.wr_data = wd; b0.rd_en = re; b0.flush = fl; b0.err_clr = ec;
    b1.wr_en = we; b1.wr_data = wd; b1.rd_en = re; b1.flush = fl; b1.err_clr = ec;
  endtask

  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit fl, input bit ec);
    drv(we, wd, re, fl, ec);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reference model: a queue of stored words plus the registered read port and error flags.
  always @(posedge CLK or negedge nRST) begin : model
    int n;
    bit ra, wa;
    if (!nRST) begin
      q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_wr_err   = 1'b0;
      m_rd_err   = 1'b0;
    end else begin
      n  = q.size();
      ra = b0.rd_en && (n > 0);
      wa = b0.wr_en && ((n < int'(DEP)) || ra);
      if (b0.flush) begin
        q.delete();
        m_rd_valid = 1'b0;
        if (b0.err_clr) begin
          m_wr_err = 1'b0;
          m_rd_err = 1'b0;
        end
      end else begin
        if (b0.wr_en && !wa)      m_wr_err = 1'b1;
        else if (b0.err_clr)      m_wr_err = 1'b0;
        if (b0.rd_en && (n == 0)) m_rd_err = 1'b1;
        else if (b0.err_clr)      m_rd_err = 1'b0;
        m_rd_valid = ra;
        if (ra) m_rd_data = q.pop_front();
        if (wa) q.push_back(b0.wr_data);
      end
    end
  end

  // Compare both instances against the model on every falling edge outside reset.
  always @(negedge CLK) begin : compare
    int n;
    logic [CW+5:0] exp0, exp1, act0, act1;
    if (chk_en && nRST) begin
      n    = q.size();
      exp0 = {CW'(n), n == int'(DEP), n == 0, n >= int'(AF), n <= int'(AE), m_wr_err, m_rd_err, m_rd_valid};
      exp1 = {CW'(n), n == int'(DEP), n == 0, n >= int'(AF), n <= int'(AE), m_wr_err, m_rd_err, n != 0};
      act0 = {b0.count, b0.full, b0.empty, b0.almost_full, b0.almost_empty, b0.wr_err, b0.rd_err, b0.rd_valid};
      act1 = {b1.count, b1.full, b1.empty, b1.almost_full, b1.almost_empty, b1.wr_err, b1.rd_err, b1.rd_valid};
      chk("reg_status", 64'(act0), 64'(exp0));
      chk("reg_rd_data", 64'(b0.rd_data), 64'(m_rd_data));
      chk("sa_status", 64'(act1), 64'(exp1));
      if (n != 0) chk("sa_rd_data", 64'(b1.rd_data), 64'(q[0]));
    end
  end

  task automatic rand_steps(input int cycles);
    bit we, re;
    for (int i = 0; i < cycles; i++) begin
      if (((i / 150) % 2) == 0) begin
        we = ($urandom_range(0, 9) < 7);
        re = ($urandom_range(0, 9) < 4);
      end else begin
        we = ($urandom_range(0, 9) < 4);
        re = ($urandom_range(0, 9) < 7);
      end
      step(we, DW'($urandom), re, ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_count", 64'(b0.count), 64'd0);
    chk("rst_flags", 64'({b0.full, b0.empty, b0.almost_full, b0.almost_empty}), 64'b0101);
    chk("rst_rd", 64'({b0.rd_valid, b0.rd_data}), 64'd0);
    chk("rst_err", 64'({b0.wr_err, b0.rd_err}), 64'd0);
    nRST   = 1'b1;
    chk_en = 1'b1;

    // Show-ahead: head word visible the cycle after the write edge.
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("sa_first", 64'({b1.rd_valid, b1.rd_data}), 64'h111);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("sa_second", 64'({b1.rd_valid, b1.rd_data}), 64'h122);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("sa_drained", 64'(b1.rd_valid), 64'd0);

    // Fill to full, then overflow.
    for (int i = 0; i < 32; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      if (i == 26) chk("af_at_27", 64'(b0.almost_full), 64'd0);
      if (i == 27) chk("af_at_28", 64'(b0.almost_full), 64'd1);
    end
    chk("full_count", 64'({b0.full, b0.count}), 64'({1'b1, 6'd32}));
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("overflow", 64'({b0.wr_err, b0.count}), 64'({1'b1, 6'd32}));

    // Drain in order with one-cycle latency, then underflow.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_data", 64'({b0.rd_valid, b0.rd_data}), 64'({1'b1, DW'(i)}));
    end
    chk("drain_empty", 64'(b0.empty), 64'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("underflow", 64'({b0.rd_err, b0.rd_valid}), 64'b10);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("err_clr", 64'({b0.wr_err, b0.rd_err}), 64'd0);

    // Simultaneous read/write at 31 and at full across pointer wrap.
    for (int i = 0; i < 31; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, DW'(8'h80 + i), 1'b1, 1'b0, 1'b0);
    chk("rw31", 64'({b0.count, b0.rd_data}), 64'({6'd31, 8'h88}));
    step(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, DW'(8'hC1 + i), 1'b1, 1'b0, 1'b0);
    chk("rw32", 64'({b0.count, b0.wr_err, b0.rd_data}), 64'({6'd32, 1'b0, 8'hC8}));

    // Read+write on empty: write lands, read flagged, no bypass.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("flush_empty", 64'({b0.count, b0.empty}), 64'({6'd0, 1'b1}));
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    chk("rw_empty", 64'({b0.count, b0.rd_err, b0.rd_valid}), 64'({6'd1, 1'b1, 1'b0}));
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rw_empty_rd", 64'({b0.rd_valid, b0.rd_data}), 64'h1A5);

    // Flush beats a concurrent write and leaves sticky flags alone.
    for (int i = 0; i < 10; i++) step(1'b1, DW'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("flush_wr", 64'({b0.count, b0.empty, b0.wr_err, b0.rd_err, b0.rd_valid}),
        64'({6'd0, 1'b1, 1'b0, 1'b1, 1'b0}));
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("flush_errclr", 64'(b0.rd_err), 64'd0);

    rand_steps(3000);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h30 + i), 1'b1, 1'b0, 1'b0);
    drv(1'b1, 8'h3F, 1'b1, 1'b0, 1'b0);
    #2;
    chk_en = 1'b0;
    nRST   = 1'b0;
    #1;
    chk("async_count", 64'({b0.count, b0.full, b0.empty}), 64'({6'd0, 1'b0, 1'b1}));
    chk("async_rd", 64'({b0.rd_valid, b0.rd_data, b0.wr_err, b0.rd_err}), 64'd0);
    chk("async_ae", 64'({b0.almost_full, b0.almost_empty}), 64'b01);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    rand_steps(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
